// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and helpers for the edge event arbiter: FSM state encoding,
// channel-count ceiling and the modulo-wrap index helper.
package edge_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int MAX_N = 16;

    // Index following idx in a ring of n entries.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N-1 back to 0.
module edge_event_arbiter_rr_pick
    import edge_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           gnt_any,
    output logic [IDW-1:0] gnt_idx
);

    logic           gnt_any_s;
    logic [IDW-1:0] gnt_idx_s;
    logic [IDW:0]   cand_s;

    // Walk the ring from ptr; the first requester encountered wins.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        cand_s    = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = {1'b0, ptr} + (IDW+1)'(k);
            if (cand_s >= (IDW+1)'(N)) begin
                cand_s = cand_s - (IDW+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_any_s && req[cand_s[IDW-1:0]]) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = cand_s[IDW-1:0];
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    assign gnt_any = gnt_any_s;
    assign gnt_idx = gnt_idx_s;

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge detector per level channel, pending/overflow latches and a
// round-robin valid/ready event port. Define EDGE_EVENT_ARBITER_SYNC_EN to add
// a 2-flop input synchronizer so level may be asynchronous.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   level,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [IDW-1:0] evt_id,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   overflow,
    input  logic           ovf_clr
);

    logic [N-1:0]   lvl_s;
    logic [N-1:0]   delay_r;
    logic [N-1:0]   edge_s;
    logic [N-1:0]   pending_r;
    logic [N-1:0]   overflow_r;
    logic [N-1:0]   req_s;
    logic [N-1:0]   gnt_vec_s;
    logic           gnt_any_s;
    logic [IDW-1:0] gnt_idx_s;
    logic           do_grant_s;
    state_t         state_r;
    logic           evt_valid_r;
    logic [IDW-1:0] evt_id_r;
    logic [IDW-1:0] ptr_r;

`ifdef EDGE_EVENT_ARBITER_SYNC_EN
    logic [N-1:0] sync1_r;
    logic [N-1:0] sync2_r;

    // Two-stage synchronizer ahead of the edge detector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= level;
            sync2_r <= sync1_r;
        end
    end

    assign lvl_s = sync2_r;
`else
    assign lvl_s = level;
`endif

    // One delay flop per channel; delay=0 out of reset so a level already
    // high at deassertion still produces an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay_r <= '0;
        end else begin
            delay_r <= lvl_s;
        end
    end

    assign edge_s = lvl_s & ~delay_r;

    // Only registered pending bits are eligible; the presented channel's own
    // bit was cleared at its grant, so a set bit here is always a fresh event.
    always_comb begin
        req_s = '0;
        if (state_r == IDLE) begin
            req_s = pending_r;
        end else if (evt_ready) begin
            req_s = pending_r;
        end else begin
            req_s = '0;
        end
    end

    edge_event_arbiter_rr_pick #(.N(N)) u_pick (
        .req     (req_s),
        .ptr     (ptr_r),
        .gnt_any (gnt_any_s),
        .gnt_idx (gnt_idx_s)
    );

    assign do_grant_s = gnt_any_s;

    // One-hot view of the channel granted this cycle.
    always_comb begin
        gnt_vec_s = '0;
        if (do_grant_s) begin
            gnt_vec_s[gnt_idx_s] = 1'b1;
        end else begin
            gnt_vec_s = '0;
        end
    end

    // Edge sets, grant clears, edge wins a collision; merged edges go sticky.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r  <= '0;
            overflow_r <= '0;
        end else begin
            pending_r  <= edge_s | (pending_r & ~gnt_vec_s);
            overflow_r <= (ovf_clr ? {N{1'b0}} : overflow_r)
                        | (edge_s & pending_r & ~gnt_vec_s);
        end
    end

    // Output FSM: a handshake with more work pending loads the next winner
    // directly, giving one event per cycle under continuous ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            evt_valid_r <= 1'b0;
            evt_id_r    <= '0;
            ptr_r       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (do_grant_s) begin
                        state_r     <= PRESENT;
                        evt_valid_r <= 1'b1;
                        evt_id_r    <= gnt_idx_s;
                        ptr_r       <= IDW'(next_idx(32'(gnt_idx_s), 32'(N)));
                    end else begin
                        evt_valid_r <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (evt_ready) begin
                        if (do_grant_s) begin
                            evt_id_r <= gnt_idx_s;
                            ptr_r    <= IDW'(next_idx(32'(gnt_idx_s), 32'(N)));
                        end else begin
                            state_r     <= IDLE;
                            evt_valid_r <= 1'b0;
                        end
                    end else begin
                        evt_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    evt_valid_r <= 1'b0;
                    evt_id_r    <= '0;
                end
            endcase
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_id    = evt_id_r;
    assign pending   = pending_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: stimulus pushes expected channel IDs,
// a negedge monitor pops them on every handshake and checks stall stability.
module tb_edge_event_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] level;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic       ovf_clr;

    int errors = 0;
    int checks = 0;
    int sb_q[$];
    int exp_id;
    logic       stall_seen = 1'b0;
    logic [1:0] stall_id = 2'd0;

    edge_event_arbiter #(.N(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .level     (level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Monitor: pop expected ID on every handshake; a stalled event must hold.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                checks++;
                if (!(evt_valid === 1'b1 && evt_id === stall_id)) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b id=%0d want valid=1 id=%0d",
                             evt_valid, evt_id, stall_id);
                end
            end
            if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL evt_unexpected: got id=%0d want no event", evt_id);
                end else begin
                    exp_id = sb_q.pop_front();
                    if (32'(evt_id) != exp_id) begin
                        errors++;
                        $display("FAIL evt_id: got %0d want %0d", evt_id, exp_id);
                    end
                end
            end
            stall_seen = (evt_valid === 1'b1) && (evt_ready === 1'b0);
            stall_id   = evt_id;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        level     = 4'b0000;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Wait for every expected event to be consumed, then confirm the port idles.
    task automatic drain(input string nm);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d events outstanding want 0", nm, sb_q.size());
        end
        tick();
        @(negedge clk);
        chk({nm, "_idle_valid"}, 32'(evt_valid), 32'd0);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_valid",    32'(evt_valid), 32'd0);
        chk("rst_id",       32'(evt_id),    32'd0);
        chk("rst_pending",  32'(pending),   32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);

        // Single edge: pending one cycle later, event the cycle after that.
        evt_ready = 1'b1;
        tick();
        level = 4'b0001;
        sb_q.push_back(0);
        @(negedge clk);
        chk("single_pre_valid", 32'(evt_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("single_pending", 32'(pending),   32'h1);
        chk("single_lat_vld", 32'(evt_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("single_valid", 32'(evt_valid), 32'd1);
        chk("single_id",    32'(evt_id),    32'd0);
        tick();
        @(negedge clk);
        chk("single_one_cycle", 32'(evt_valid), 32'd0);
        chk("single_pend_clr",  32'(pending),   32'd0);
        drain("single");

        // Backpressure: ch0 held through the stall, then ch2 back-to-back.
        do_reset();
        tick();
        level = 4'b0101;
        sb_q.push_back(0);
        sb_q.push_back(2);
        repeat (5) tick();
        @(negedge clk);
        chk("bp_stall_valid", 32'(evt_valid), 32'd1);
        chk("bp_stall_id",    32'(evt_id),    32'd0);
        tick();
        evt_ready = 1'b1;
        drain("bp");

        // Fairness: all four re-trigger every 4 cycles, grants rotate 0..3.
        do_reset();
        evt_ready = 1'b1;
        tick();
        for (int p = 0; p < 10; p++) begin
            level = 4'b1111;
            for (int c = 0; c < 4; c++) sb_q.push_back(c);
            tick();
            tick();
            level = 4'b0000;
            tick();
            tick();
        end
        drain("rr");
        chk("rr_no_overflow", 32'(overflow), 32'd0);

        // Overflow: ch1 re-fires while ch0 is stalled and ch1 already pending.
        do_reset();
        tick();
        level = 4'b0001;
        sb_q.push_back(0);
        sb_q.push_back(1);
        tick();
        tick();
        level = 4'b0011;
        tick();
        level = 4'b0001;
        tick();
        level = 4'b0011;
        tick();
        @(negedge clk);
        chk("ovf_set",     32'(overflow), 32'h2);
        chk("ovf_pending", 32'(pending),  32'h2);
        tick();
        evt_ready = 1'b1;
        drain("ovf");
        chk("ovf_sticky", 32'(overflow), 32'h2);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Same-cycle edge and grant on ch3: pending stays set, ch3 delivered twice.
        do_reset();
        tick();
        level = 4'b1001;
        sb_q.push_back(0);
        sb_q.push_back(3);
        sb_q.push_back(3);
        tick();
        tick();
        level = 4'b0001;
        tick();
        level     = 4'b1001;
        evt_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("same_pending3", 32'(pending[3]), 32'd1);
        chk("same_id",       32'(evt_id),     32'd3);
        drain("same");
        chk("same_no_ovf", 32'(overflow), 32'd0);

        // Async reset between clocks while an event is presented and overflow set.
        do_reset();
        tick();
        level = 4'b0011;
        sb_q.push_back(0);
        tick();
        tick();
        level = 4'b0001;
        tick();
        level = 4'b0011;
        tick();
        @(negedge clk);
        chk("arst_pre_valid", 32'(evt_valid), 32'd1);
        chk("arst_pre_ovf",   32'(overflow),  32'h2);
        #2;
        reset_n = 1'b0;
        level   = 4'b0100;
        sb_q.delete();
        #1;
        chk("arst_valid",    32'(evt_valid), 32'd0);
        chk("arst_pending",  32'(pending),   32'd0);
        chk("arst_overflow", 32'(overflow),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        evt_ready = 1'b1;
        sb_q.push_back(2);
        drain("arst_held_high");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
